// File: rtl/dense_layer_sched.sv
// Dense-layer scheduler: time-multiplexes one perceptron datapath across NUM_NEURONS neurons.
// Optional neuron skipping is enabled by defining DENSE_SCHED_NEURON_MASK_EN.
module dense_layer_sched #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_x1,
  input  logic [3:0]             in_x2,
  input  logic                   cfg_we,
  output logic                   cfg_ready,
  input  logic [IDX_W-1:0]       cfg_addr,
  input  logic [3:0]             cfg_w1,
  input  logic [3:0]             cfg_w2,
  input  logic [5:0]             cfg_bias,
  output logic [3:0]             pe_x1,
  output logic [3:0]             pe_x2,
  output logic [3:0]             pe_w1,
  output logic [3:0]             pe_w2,
  output logic [5:0]             pe_bias,
  input  logic                   pe_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_vec,
`ifdef DENSE_SCHED_NEURON_MASK_EN
  input  logic                   cfg_mask_we,
  input  logic [NUM_NEURONS-1:0] cfg_mask,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [3:0]             x1_q, x2_q;
  logic [3:0]             wf_w1   [NUM_NEURONS];
  logic [3:0]             wf_w2   [NUM_NEURONS];
  logic [5:0]             wf_bias [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] mask;
  logic                   accept;
  logic                   addr_ok;
  logic                   first_found, next_found;
  logic [IDX_W-1:0]       first_idx, next_idx;

`ifdef DENSE_SCHED_NEURON_MASK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask <= '1;
    end else if (cfg_mask_we && cfg_ready) begin
      mask <= cfg_mask;
    end
  end
`else
  assign mask = '1;
`endif

  // Lowest enabled neuron starts a vector; the next enabled neuron above idx follows.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (mask[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (mask[i] && !next_found && (i > int'(idx))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    cfg_ready = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = first_found ? RUN : DONE;
        end
      end
      RUN: begin
        busy      = 1'b1;
        cfg_ready = 1'b0;
        if (!next_found) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = (state == IDLE) && in_valid;
  assign addr_ok = (32'(cfg_addr) < NUM_NEURONS);

  // out_vec is cleared on accept so skipped neurons read back as 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      out_vec <= '0;
    end else if (accept) begin
      idx     <= first_idx;
      x1_q    <= in_x1;
      x2_q    <= in_x2;
      out_vec <= '0;
    end else if (state == RUN) begin
      out_vec[idx] <= pe_out;
      if (next_found) begin
        idx <= next_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        wf_w1[i]   <= '0;
        wf_w2[i]   <= '0;
        wf_bias[i] <= '0;
      end
    end else if (cfg_we && cfg_ready && addr_ok) begin
      wf_w1[cfg_addr]   <= cfg_w1;
      wf_w2[cfg_addr]   <= cfg_w2;
      wf_bias[cfg_addr] <= cfg_bias;
    end
  end

  assign pe_x1   = x1_q;
  assign pe_x2   = x2_q;
  assign pe_w1   = wf_w1[idx];
  assign pe_w2   = wf_w2[idx];
  assign pe_bias = wf_bias[idx];

endmodule

// File: tb/tb_dense_layer_sched.sv
// Scoreboard testbench for dense_layer_sched with a behavioural perceptron stub on pe_out.
// Mask scenarios run only when DENSE_SCHED_NEURON_MASK_EN is defined.
module tb_dense_layer_sched;

  localparam int N     = 4;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_x1 = '0;
  logic [3:0]       in_x2 = '0;
  logic             cfg_we = 1'b0;
  logic             cfg_ready;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [3:0]       cfg_w1 = '0;
  logic [3:0]       cfg_w2 = '0;
  logic [5:0]       cfg_bias = '0;
  logic [3:0]       pe_x1, pe_x2, pe_w1, pe_w2;
  logic [5:0]       pe_bias;
  logic             pe_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_vec;
  logic             busy;
`ifdef DENSE_SCHED_NEURON_MASK_EN
  logic             cfg_mask_we = 1'b0;
  logic [N-1:0]     cfg_mask = '0;
`endif

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int acc = 0;

  int           mw1 [N];
  int           mw2 [N];
  int           mb  [N];
  logic [N-1:0] mmask = '1;
  logic [N-1:0] sb [$];
  logic [3:0]   w1_log [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dense_layer_sched #(.NUM_NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_w1(cfg_w1), .cfg_w2(cfg_w2), .cfg_bias(cfg_bias),
    .pe_x1(pe_x1), .pe_x2(pe_x2), .pe_w1(pe_w1), .pe_w2(pe_w2), .pe_bias(pe_bias),
    .pe_out(pe_out), .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
`ifdef DENSE_SCHED_NEURON_MASK_EN
    .cfg_mask_we(cfg_mask_we), .cfg_mask(cfg_mask),
`endif
    .busy(busy)
  );

  function automatic logic stub(logic [3:0] x1, logic [3:0] x2, logic [3:0] w1,
                                logic [3:0] w2, logic [5:0] b);
    int s;
    s = int'($signed(x1)) * int'($signed(w1)) + int'($signed(x2)) * int'($signed(w2))
        + int'($signed(b));
    return (s >= 0);
  endfunction

  assign pe_out = stub(pe_x1, pe_x2, pe_w1, pe_w2, pe_bias);

  function automatic logic [N-1:0] model_vec(int x1, int x2);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (mmask[i] && (x1 * mw1[i] + x2 * mw2[i] + mb[i] >= 0)) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mw1[i] = 0; mw2[i] = 0; mb[i] = 0;
    end
    mmask = '1;
    sb.delete();
  endtask

  // Config write issued in IDLE; the model follows because the bench knows it lands.
  task automatic cfg_write(input int a, input int w1, input int w2, input int b);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(a);
    cfg_w1   = 4'(w1);
    cfg_w2   = 4'(w2);
    cfg_bias = 6'(b);
    @(negedge clk);
    cfg_we = 1'b0;
    if (a < N) begin
      mw1[a] = w1; mw2[a] = w2; mb[a] = b;
    end
  endtask

  task automatic load_table_weights();
    cfg_write(0, 1, 1, 0);
    cfg_write(1, -1, -1, 0);
    cfg_write(2, 2, 0, -5);
    cfg_write(3, 0, 3, 2);
  endtask

  // Called at a negedge; the accept happens at the following posedge.
  task automatic applyStimulus(input int x1, input int x2, input bit with_cfg, output logic rdy);
    rdy = in_ready;
    if (with_cfg) begin
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_w1   = 4'(-7);
      cfg_w2   = 4'(-7);
      cfg_bias = 6'(-20);
      mw1[0] = -7; mw2[0] = -7; mb[0] = -20;
    end
    in_valid = 1'b1;
    in_x1    = 4'(x1);
    in_x2    = 4'(x2);
    acc      = cyc;
    sb.push_back(model_vec(x1, x2));
  endtask

  task automatic collect(output int lat, output logic [N-1:0] vec);
    lat = -1;
    vec = 'x;
    w1_log.delete();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      if (out_valid === 1'b1) begin
        lat = cyc - acc;
        vec = out_vec;
        break;
      end
      if (busy === 1'b1) w1_log.push_back(pe_w1);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (out_vec !== '0) $display("[TB] FAIL reset_out_vec: got %b want 0", out_vec); else passed++;
    checks++; if (cfg_ready !== 1'b1) $display("[TB] FAIL reset_cfg_ready: got %b want 1", cfg_ready); else passed++;
    checks++; if ({pe_x1, pe_x2, pe_w1, pe_w2, pe_bias} !== '0)
      $display("[TB] FAIL reset_operands: got %h want 0", {pe_x1, pe_x2, pe_w1, pe_w2, pe_bias}); else passed++;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_single_vector();
    int           exp_w1 [4] = '{1, -1, 2, 0};
    int           lat;
    logic [N-1:0] vec, exp;
    logic         rdy;
    load_table_weights();
    @(negedge clk);
    applyStimulus(2, 1, 1'b0, rdy);
    checks++; if (rdy !== 1'b1) $display("[TB] FAIL single_in_ready: got %b want 1", rdy); else passed++;
    collect(lat, vec);
    checks++; if (lat != 5) $display("[TB] FAIL single_latency: got %0d want 5", lat); else passed++;
    checks++; if (w1_log.size() != 4) $display("[TB] FAIL single_run_cycles: got %0d want 4", w1_log.size()); else passed++;
    for (int i = 0; i < 4 && i < w1_log.size(); i++) begin
      checks++;
      if (w1_log[i] !== 4'(exp_w1[i]))
        $display("[TB] FAIL single_pe_w1[%0d]: got %h want %h", i, w1_log[i], 4'(exp_w1[i]));
      else passed++;
    end
    exp = sb.pop_front();
    checks++; if (vec !== exp) $display("[TB] FAIL single_out_vec: got %b want %b", vec, exp); else passed++;
    checks++; if (vec !== 4'b1001) $display("[TB] FAIL single_out_vec_table: got %b want 1001", vec); else passed++;
    release_out();
  endtask

  task automatic test_backpressure();
    int           lat;
    logic [N-1:0] vec, exp;
    logic         rdy;
    @(negedge clk);
    applyStimulus(1, -2, 1'b0, rdy);
    collect(lat, vec);
    exp = sb.pop_front();
    checks++; if (vec !== exp) $display("[TB] FAIL bp_out_vec: got %b want %b", vec, exp); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp || in_ready !== 1'b0)
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b vec=%b in_ready=%b want 1 %b 0",
                 i, out_valid, out_vec, in_ready, exp);
      else passed++;
    end
    release_out();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_out_valid: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_cfg_during_run();
    int           lat;
    logic [N-1:0] vec, exp;
    logic         rdy;
    @(negedge clk);
    applyStimulus(1, 1, 1'b0, rdy);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(2);
    cfg_w1   = 4'(-8);
    cfg_w2   = 4'(-8);
    cfg_bias = 6'(-32);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL run_busy: got %b want 1", busy); else passed++;
    checks++; if (cfg_ready !== 1'b0) $display("[TB] FAIL run_cfg_ready: got %b want 0", cfg_ready); else passed++;
    collect(lat, vec);
    checks++; if (lat != 5) $display("[TB] FAIL run_cfg_latency: got %0d want 5", lat); else passed++;
    exp = sb.pop_front();
    checks++; if (vec !== exp) $display("[TB] FAIL run_cfg_out_vec: got %b want %b", vec, exp); else passed++;
    release_out();
    @(negedge clk);
    applyStimulus(3, 0, 1'b0, rdy);
    collect(lat, vec);
    exp = sb.pop_front();
    checks++; if (vec !== exp) $display("[TB] FAIL run_cfg_next_vec: got %b want %b", vec, exp); else passed++;
    checks++; if (vec[2] !== 1'b1) $display("[TB] FAIL run_cfg_entry2: got %b want 1", vec[2]); else passed++;
    release_out();
  endtask

  task automatic test_same_cycle_cfg();
    int           lat;
    logic [N-1:0] vec, exp;
    logic         rdy;
    @(negedge clk);
    applyStimulus(1, 1, 1'b1, rdy);
    collect(lat, vec);
    checks++; if (lat != 5) $display("[TB] FAIL same_cycle_latency: got %0d want 5", lat); else passed++;
    exp = sb.pop_front();
    checks++; if (vec !== exp) $display("[TB] FAIL same_cycle_out_vec: got %b want %b", vec, exp); else passed++;
    checks++; if (vec[0] !== 1'b0) $display("[TB] FAIL same_cycle_bit0: got %b want 0", vec[0]); else passed++;
    release_out();
  endtask

  task automatic test_reset_mid_run();
    int           lat;
    logic [N-1:0] vec, exp;
    logic         rdy;
    @(negedge clk);
    applyStimulus(2, 1, 1'b0, rdy);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    checks++; if (busy !== 1'b1 || pe_w1 !== 4'(mw1[2]))
      $display("[TB] FAIL mid_run_idx2: got busy=%b pe_w1=%h want 1 %h", busy, pe_w1, 4'(mw1[2])); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_rst_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_rst_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_vec !== '0) $display("[TB] FAIL mid_rst_out_vec: got %b want 0", out_vec); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); else passed++;
    @(negedge clk);
    applyStimulus(1, -1, 1'b0, rdy);
    collect(lat, vec);
    checks++; if (lat != 5) $display("[TB] FAIL mid_rst_latency: got %0d want 5", lat); else passed++;
    for (int i = 0; i < w1_log.size(); i++) begin
      checks++;
      if (w1_log[i] !== 4'h0) $display("[TB] FAIL mid_rst_weight[%0d]: got %h want 0", i, w1_log[i]);
      else passed++;
    end
    exp = sb.pop_front();
    checks++; if (vec !== exp) $display("[TB] FAIL mid_rst_out_vec_after: got %b want %b", vec, exp); else passed++;
    release_out();
  endtask

`ifdef DENSE_SCHED_NEURON_MASK_EN
  task automatic cfg_mask_write(input logic [N-1:0] m);
    @(negedge clk);
    cfg_mask_we = 1'b1;
    cfg_mask    = m;
    @(negedge clk);
    cfg_mask_we = 1'b0;
    mmask = m;
  endtask

  task automatic test_mask();
    int           lat;
    logic [N-1:0] vec, exp;
    logic         rdy;
    load_table_weights();
    cfg_mask_write(4'b0101);
    @(negedge clk);
    applyStimulus(2, 1, 1'b0, rdy);
    collect(lat, vec);
    checks++; if (lat != 3) $display("[TB] FAIL mask_latency: got %0d want 3", lat); else passed++;
    checks++; if (w1_log.size() != 2) $display("[TB] FAIL mask_run_cycles: got %0d want 2", w1_log.size()); else passed++;
    if (w1_log.size() == 2) begin
      checks++;
      if (w1_log[0] !== 4'(1) || w1_log[1] !== 4'(2))
        $display("[TB] FAIL mask_visit_order: got %h,%h want 1,2", w1_log[0], w1_log[1]);
      else passed++;
    end
    exp = sb.pop_front();
    checks++; if (vec !== exp) $display("[TB] FAIL mask_out_vec: got %b want %b", vec, exp); else passed++;
    checks++; if (vec[1] !== 1'b0 || vec[3] !== 1'b0)
      $display("[TB] FAIL mask_skipped_bits: got %b%b want 00", vec[3], vec[1]); else passed++;
    release_out();
    cfg_mask_write('0);
    @(negedge clk);
    applyStimulus(2, 1, 1'b0, rdy);
    collect(lat, vec);
    checks++; if (lat != 1) $display("[TB] FAIL mask0_latency: got %0d want 1", lat); else passed++;
    exp = sb.pop_front();
    checks++; if (vec !== exp) $display("[TB] FAIL mask0_out_vec: got %b want %b", vec, exp); else passed++;
    release_out();
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_single_vector();
    test_backpressure();
    test_cfg_during_run();
    test_same_cycle_cfg();
    test_reset_mid_run();
`ifdef DENSE_SCHED_NEURON_MASK_EN
    test_mask();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
